// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART TX byte port among
// N_REQ valid/ready requesters, with a stall watchdog that reclaims a silent grantee.
module uart_tx_arbiter #(
   parameter  int N_REQ   = 4,
   parameter  int TIMEOUT = 1024,
   localparam int ID_W    = $clog2(N_REQ)
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic               out_valid,
   output logic [7:0]         out_data,
   input  logic               out_ready,
   output logic               busy,
   output logic [ID_W-1:0]    grant_id,
   output logic               abort,
   output logic [ID_W-1:0]    abort_id
);

   localparam int               CNT_W      = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic {IDLE, SEND} state_e;

   state_e           state_q, state_d;
   logic [ID_W-1:0]  grant_q, grant_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             abort_q, abort_d;
   logic [ID_W-1:0]  abort_id_q, abort_id_d;

   logic             pick_found;
   logic [ID_W-1:0]  pick;
   logic [ID_W-1:0]  cand;

   // grant_q doubles as last_grant: scan starts just above the previous grantee
   always_comb begin
      pick_found = 1'b0;
      pick       = grant_q;
      cand       = grant_q;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = ID_W'((int'(grant_q) + k) % N_REQ);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick       = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      stall_cnt_d = stall_cnt_q;
      abort_d     = 1'b0;
      abort_id_d  = abort_id_q;
      req_ready   = '0;
      out_valid   = 1'b0;
      out_data    = 8'h00;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d     = pick;
               state_d     = SEND;
               stall_cnt_d = '0;
            end
         end
         SEND: begin
            out_valid          = req_valid[grant_q];
            out_data           = out_valid ? req_data[{grant_q, 3'b000} +: 8] : 8'h00;
            req_ready[grant_q] = out_ready;
            // valid high with out_ready low is UART backpressure: counter untouched
            if (req_valid[grant_q]) begin
               if (out_ready) begin
                  if (req_last[grant_q]) state_d = IDLE;
                  else                   stall_cnt_d = '0;
               end
            end else if (stall_cnt_q == STALL_LAST) begin
               state_d    = IDLE;
               abort_d    = 1'b1;
               abort_id_d = grant_q;
            end else if (stall_cnt_q != CNT_MAX) begin
               stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= ID_W'(N_REQ - 1);
         stall_cnt_q <= '0;
         abort_q     <= 1'b0;
         abort_id_q  <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         stall_cnt_q <= stall_cnt_d;
         abort_q     <= abort_d;
         abort_id_q  <= abort_id_d;
      end
   end

   assign busy     = (state_q == SEND);
   assign grant_id = grant_q;
   assign abort    = abort_q;
   assign abort_id = abort_id_q;

endmodule
